// File: rtl/exu_muldiv_seq.sv
// Multi-cycle integer multiply/divide unit for the execute stage.
// Multiply completes after MUL_LAT cycles; divide is radix-2 restoring with an early-out for special cases.
module exu_muldiv_seq #(
    parameter int XLEN    = 64,
    parameter int MUL_LAT = 3,
    parameter int TAG_W   = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  src1,
    input  logic [XLEN-1:0]  src2,
    input  logic [2:0]       op,
    input  logic             is_word,
    input  logic [4:0]       rd,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [4:0]       rd_out,
    output logic [TAG_W-1:0] tag_out,
    output logic             busy,
    output logic [1:0]       state_dbg
);
    // Handshake: a request transfers on a rising edge where in_valid && in_ready && !flush;
    // a result transfers on a rising edge where out_valid && out_ready. Both sides hold until transfer.

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam int CW = $clog2(((XLEN > MUL_LAT) ? XLEN : MUL_LAT) + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] a_q, b_q, r_q;
    logic [2:0]      op_q;
    logic            word_q, neg_q, neg_r;

    function automatic logic [XLEN-1:0] fit32(input logic [XLEN-1:0] x, input logic word,
                                              input logic sgn);
        logic [XLEN-1:0] v;
        v = x;
        if (word) begin
            for (int i = 32; i < XLEN; i++) v[i] = sgn & x[31];
        end
        return v;
    endfunction

    logic            in_word, in_is_div, in_div_signed, in_rem, a_sgn, b_sgn;
    logic            a_neg, b_neg, div_zero, div_ovf, special, accept;
    logic [XLEN-1:0] a_eff, b_eff, a_mag, b_mag, most_neg, sp_res;

    always_comb begin
        in_word       = (XLEN == 64) && is_word;
        in_is_div     = op[2];
        in_div_signed = in_is_div && !op[0];
        in_rem        = in_is_div && op[1];
        a_sgn         = in_is_div ? in_div_signed : (op == OP_MULH || op == OP_MULHSU);
        b_sgn         = in_is_div ? in_div_signed : (op == OP_MULH);
        a_eff         = fit32(src1, in_word, a_sgn);
        b_eff         = fit32(src2, in_word, b_sgn);
        a_neg         = in_div_signed && a_eff[XLEN-1];
        b_neg         = in_div_signed && b_eff[XLEN-1];
        a_mag         = a_neg ? -a_eff : a_eff;
        b_mag         = b_neg ? -b_eff : b_eff;
        most_neg      = '0;
        most_neg[XLEN-1] = 1'b1;
        if (in_word) most_neg = {XLEN{1'b1}} << 31;
        div_zero      = (b_eff == '0);
        div_ovf       = in_div_signed && (a_eff == most_neg) && (b_eff == '1);
        special       = in_is_div && (div_zero || div_ovf);
        if (div_zero) sp_res = in_rem ? a_eff : '1;
        else          sp_res = in_rem ? '0 : a_eff;
    end

    assign accept = in_valid && in_ready && !flush;

    // Multiplier operands carry one extra sign bit so all three high-half variants share one product.
    logic            m_sa, m_sb;
    logic [XLEN:0]   m_a, m_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] mul_res;

    always_comb begin
        m_sa    = (op_q == OP_MULH) || (op_q == OP_MULHSU);
        m_sb    = (op_q == OP_MULH);
        m_a     = {m_sa & a_q[XLEN-1], a_q};
        m_b     = {m_sb & b_q[XLEN-1], b_q};
        prod    = {{(XLEN-1){m_a[XLEN]}}, m_a} * {{(XLEN-1){m_b[XLEN]}}, m_b};
        mul_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end

    logic [XLEN:0]   r_sh, r_sub;
    logic [XLEN-1:0] quo, remv, div_res;
    logic [CW-1:0]   n_iter;
    logic            mul_last, div_last;

    always_comb begin
        r_sh     = {r_q, a_q[XLEN-1]};
        r_sub    = r_sh - {1'b0, b_q};
        quo      = neg_q ? -a_q : a_q;
        remv     = neg_r ? -r_q : r_q;
        div_res  = op_q[1] ? remv : quo;
        n_iter   = word_q ? CW'(32) : CW'(XLEN);
        mul_last = (cnt == CW'(MUL_LAT - 1));
        div_last = (cnt == n_iter);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept) state_nx = !op[2] ? S_MUL : (special ? S_DONE : S_DIV);
                S_MUL:  if (mul_last) state_nx = S_DONE;
                S_DIV:  if (div_last) state_nx = S_DONE;
                S_DONE: if (out_ready) state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
        busy      = (state != S_IDLE);
        state_dbg = state;
    end

    // Divide keeps the quotient shift register in a_q; word divides are left-aligned so 32 shifts suffice.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            op_q    <= '0;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            result  <= '0;
            rd_out  <= '0;
            tag_out <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= op;
                        word_q  <= in_word;
                        rd_out  <= rd;
                        tag_out <= tag_in;
                        cnt     <= '0;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        r_q     <= '0;
                        if (op[2]) begin
                            a_q <= in_word ? (a_mag << 32) : a_mag;
                            b_q <= b_mag;
                        end else begin
                            a_q <= a_eff;
                            b_q <= b_eff;
                        end
                        if (special) result <= fit32(sp_res, in_word, 1'b1);
                    end
                end
                S_MUL: begin
                    cnt <= cnt + CW'(1);
                    if (mul_last) result <= fit32(mul_res, word_q, 1'b1);
                end
                S_DIV: begin
                    cnt <= cnt + CW'(1);
                    if (div_last) begin
                        result <= fit32(div_res, word_q, 1'b1);
                    end else begin
                        r_q <= r_sub[XLEN] ? r_sh[XLEN-1:0] : r_sub[XLEN-1:0];
                        a_q <= {a_q[XLEN-2:0], ~r_sub[XLEN]};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_exu_muldiv_seq.sv
// Directed bench for exu_muldiv_seq (XLEN=64, MUL_LAT=3): latency, results, specials, backpressure, flush, reset.
module tb_exu_muldiv_seq;
    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic        clock, reset, flush, in_valid, in_ready, is_word, out_valid, out_ready, busy;
    logic [63:0] src1, src2, result;
    logic [2:0]  op;
    logic [4:0]  rd, rd_out, rd_v;
    logic [5:0]  tag_in, tag_out, tag_v;
    logic [1:0]  state_dbg;
    int          total, bad;

    exu_muldiv_seq #(.XLEN(64), .MUL_LAT(3), .TAG_W(6)) dut (
        .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .op(op), .is_word(is_word), .rd(rd), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .rd_out(rd_out),
        .tag_out(tag_out), .busy(busy), .state_dbg(state_dbg)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic w);
        @(negedge clock);
        op = o; src1 = a; src2 = b; is_word = w; rd = rd_v; tag_in = tag_v; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic do_op(input string name, input logic [2:0] o, input logic [63:0] a,
                         input logic [63:0] b, input logic w, input int exp_lat,
                         input logic [63:0] exp_res);
        int lat;
        rd_v  = rd_v + 5'd3;
        tag_v = tag_v + 6'd5;
        issue(o, a, b, w);
        wait_valid(lat);
        check({name, "_lat"}, 64'(lat), 64'(exp_lat));
        check({name, "_res"}, result, exp_res);
        check({name, "_rd"}, 64'(rd_out), 64'(rd_v));
        check({name, "_tag"}, 64'(tag_out), 64'(tag_v));
        @(posedge clock); #1;
        check({name, "_idle"}, 64'({in_ready, out_valid}), 64'(2'b10));
    endtask

    initial begin
        int lat, seen;
        total = 0; bad = 0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        src1 = '0; src2 = '0; op = '0; is_word = 1'b0; rd = '0; tag_in = '0;
        rd_v = 5'd1; tag_v = 6'd2;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_ready", 64'(in_ready), 64'(1));
        check("rst_result", result, 64'h0);
        check("rst_rd", 64'(rd_out), 64'(0));
        check("rst_tag", 64'(tag_out), 64'(0));

        do_op("mul", OP_MUL, 64'd7, -64'sd3, 1'b0, 3, 64'hFFFFFFFFFFFFFFEB);
        do_op("mulhu", OP_MULHU, 64'hFFFFFFFFFFFFFFFF, 64'd2, 1'b0, 3, 64'd1);
        do_op("mulh", OP_MULH, -64'sd1, -64'sd1, 1'b0, 3, 64'd0);
        do_op("mulhsu", OP_MULHSU, -64'sd1, 64'd2, 1'b0, 3, 64'hFFFFFFFFFFFFFFFF);
        do_op("mulw", OP_MUL, 64'h000000007FFFFFFF, 64'd2, 1'b1, 3, 64'hFFFFFFFFFFFFFFFE);
        do_op("div", OP_DIV, -64'sd20, 64'd3, 1'b0, 65, 64'hFFFFFFFFFFFFFFFA);
        do_op("rem", OP_REM, -64'sd20, 64'd3, 1'b0, 65, 64'hFFFFFFFFFFFFFFFE);
        do_op("div_pn", OP_DIV, 64'd20, -64'sd3, 1'b0, 65, 64'hFFFFFFFFFFFFFFFA);
        do_op("rem_pn", OP_REM, 64'd20, -64'sd3, 1'b0, 65, 64'd2);
        do_op("divu", OP_DIVU, 64'hFFFFFFFFFFFFFFFF, 64'h10, 1'b0, 65, 64'h0FFFFFFFFFFFFFFF);
        do_op("divw_ovf", OP_DIV, 64'h0000000080000000, 64'h00000000FFFFFFFF, 1'b1, 0,
              64'hFFFFFFFF80000000);
        do_op("div_ovf", OP_DIV, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b0, 0,
              64'h8000000000000000);
        do_op("rem_ovf", OP_REM, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b0, 0, 64'd0);
        do_op("divu0", OP_DIVU, 64'd5, 64'd0, 1'b0, 0, 64'hFFFFFFFFFFFFFFFF);
        do_op("remu0", OP_REMU, 64'd5, 64'd0, 1'b0, 0, 64'd5);
        do_op("divuw", OP_DIVU, 64'd100, 64'd7, 1'b1, 33, 64'd14);
        do_op("remw", OP_REM, 64'h00000000FFFFFFF9, 64'd2, 1'b1, 33, 64'hFFFFFFFFFFFFFFFF);

        // Backpressure: result must hold in DONE and a pending request must wait.
        out_ready = 1'b0;
        rd_v = rd_v + 5'd3; tag_v = tag_v + 6'd5;
        issue(OP_MUL, 64'd6, 64'd7, 1'b0);
        wait_valid(lat);
        check("bp_lat", 64'(lat), 64'(3));
        op = OP_DIVU; src1 = 64'd99; src2 = 64'd0; rd = 5'd0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_res", result, 64'd42);
            check("bp_rd", 64'(rd_out), 64'(rd_v));
            check("bp_ready", 64'({in_ready, out_valid}), 64'(2'b01));
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clock); #1;
        check("bp_release", 64'({in_ready, out_valid, busy}), 64'(3'b100));

        // Flush at divide iteration 20 with a competing request in the same cycle.
        rd_v = rd_v + 5'd3; tag_v = tag_v + 6'd5;
        issue(OP_DIV, 64'd1000, 64'd3, 1'b0);
        repeat (20) @(posedge clock);
        @(negedge clock);
        flush = 1'b1; in_valid = 1'b1; op = OP_MUL; src1 = 64'd2; src2 = 64'd3; is_word = 1'b0;
        @(posedge clock); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_state", 64'({in_ready, out_valid, busy}), 64'(3'b100));
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (out_valid === 1'b1 || busy === 1'b1) seen++;
            @(posedge clock); #1;
        end
        check("flush_quiet", 64'(seen), 64'(0));
        do_op("post_flush", OP_MUL, 64'd9, 64'd9, 1'b0, 3, 64'd81);

        // Asynchronous reset in the middle of a divide clears everything at once.
        issue(OP_DIV, 64'd12345, 64'd7, 1'b0);
        repeat (10) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("amid_rst_state", 64'({out_valid, busy}), 64'(2'b00));
        check("amid_rst_result", result, 64'd0);
        check("amid_rst_tag", 64'({rd_out, tag_out}), 64'(0));
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("amid_rst_ready", 64'(in_ready), 64'(1));
        do_op("post_rst", OP_DIVU, 64'd12345, 64'd7, 1'b0, 65, 64'd1763);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
